// File: rtl/mem_array_ctrl.sv
// -----------------------------------------------------------------------------
// mem_array_ctrl
//
// Single-port-address word array with byte-enable writes, a self-initialising
// fill sweep after reset, and a fixed-latency read pipeline.
//
// After reset the controller sweeps every word, writing FILL_VAL to one address
// per clock in ascending order. It then enters RUN, where read and write
// requests are serviced. Requests that arrive before RUN are dropped and
// flagged on err.
//
// Request / response protocol:
//   Requests are accepted on a rising edge only while ready is high. There is
//   no backpressure: every accepted read produces exactly one rd_valid pulse
//   1+RD_PIPE cycles after the edge that sampled it, and data_rd is meaningful
//   only while rd_valid is high (it holds its previous value otherwise).
//   A request presented while ready is low is ignored and produces a one-cycle
//   err pulse on the following cycle.
//
// Parameters:
//   ADDRESS_W  address width, depth = 2**ADDRESS_W words
//   DATA_W     word width, must be a multiple of 8
//   RD_PIPE    extra read output register stages (0 or 1)
//   FILL_VAL   value written to every word by the init sweep
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   address    word address for read or write
//   write_en   write request
//   read_en    read request
//   byte_en    per-byte write mask, bit i covers data_wr[8i+7:8i]
//   data_wr    write data
//   data_rd    read data, valid while rd_valid is high
//   rd_valid   one-cycle pulse per accepted read
//   ready      high once the init sweep is complete
//   err        one-cycle pulse for a request received while not ready
//   dbg_state  current FSM state (0 = INIT, 1 = RUN)
// -----------------------------------------------------------------------------
module mem_array_ctrl #(
    parameter int                ADDRESS_W = 4,
    parameter int                DATA_W    = 16,
    parameter int                RD_PIPE   = 0,
    parameter logic [DATA_W-1:0] FILL_VAL  = {DATA_W{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDRESS_W-1:0]  address,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic [DATA_W-1:0]     data_wr,
    output logic [DATA_W-1:0]     data_rd,
    output logic                  rd_valid,
    output logic                  ready,
    output logic                  err,
    output logic                  dbg_state
);

    localparam int DEPTH  = 2 ** ADDRESS_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // One bit wider than the address: the MSB marks "sweep finished" so the
    // counter parks at DEPTH instead of wrapping into a second sweep.
    logic [ADDRESS_W:0] cnt_q, cnt_d;

    logic sweep_we;
    logic wr_req;
    logic rd_req;
    logic err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              rd_s1_valid_q;
    logic [DATA_W-1:0] rd_s1_data_q;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;

    logic              rd_valid_q;
    logic [DATA_W-1:0] data_rd_q;
    logic              err_q;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and request qualification
    // INIT spends DEPTH cycles writing the fill value, then one more cycle with
    // the sweep finished before moving to RUN; ready follows the registered
    // state, so it rises on the edge after the last sweep write.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_INIT: begin
                err_d = write_en | read_en;
                if (!cnt_q[ADDRESS_W]) begin
                    sweep_we = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_req = write_en;
                rd_req = read_en;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Storage array. Not reset: contents are only established by the sweep.
    // A write with every byte_en bit low naturally touches nothing.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem_q[cnt_q[ADDRESS_W-1:0]] <= FILL_VAL;
        end else if (wr_req) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (byte_en[b]) begin
                    mem_q[address][b*8 +: 8] <= data_wr[b*8 +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read stage 1: captures the array on the same edge as any write, so a
    // same-address read returns the pre-write word.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_s1_valid_q <= 1'b0;
            rd_s1_data_q  <= '0;
        end else begin
            rd_s1_valid_q <= rd_req;
            if (rd_req) begin
                rd_s1_data_q <= mem_q[address];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional extra read stage
    // -------------------------------------------------------------------------
    generate
        if (RD_PIPE == 1) begin : g_rd_pipe
            logic              rd_s2_valid_q;
            logic [DATA_W-1:0] rd_s2_data_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_s2_valid_q <= 1'b0;
                    rd_s2_data_q  <= '0;
                end else begin
                    rd_s2_valid_q <= rd_s1_valid_q;
                    if (rd_s1_valid_q) begin
                        rd_s2_data_q <= rd_s1_data_q;
                    end
                end
            end

            assign pipe_valid = rd_s2_valid_q;
            assign pipe_data  = rd_s2_data_q;
        end else begin : g_no_rd_pipe
            assign pipe_valid = rd_s1_valid_q;
            assign pipe_data  = rd_s1_data_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output registers. data_rd only loads on a valid beat so it holds
    // between pulses; everything clears asynchronously, dropping any read
    // still in the pipeline.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            data_rd_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= pipe_valid;
            if (pipe_valid) begin
                data_rd_q <= pipe_data;
            end
            err_q <= err_d;
        end
    end

    assign data_rd   = data_rd_q;
    assign rd_valid  = rd_valid_q;
    assign err       = err_q;
    assign ready     = (state_q == ST_RUN);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_array_ctrl
//
// Drives two instances side by side (RD_PIPE = 0 and RD_PIPE = 1) with the
// same stimulus. A reference model counts clock edges since reset release to
// decide when the array is filled and requests are accepted, keeps the array
// contents in a plain array, and queues expected read data with the cycle it
// is due. A scoreboard compares every output of both instances every cycle;
// the scenario tasks add directed checks of their own.
// -----------------------------------------------------------------------------
module tb_mem_array_ctrl;

    localparam int              AW    = 4;
    localparam int              DW    = 16;
    localparam int              NB    = DW / 8;
    localparam int              DEPTH = 2 ** AW;
    localparam logic [DW-1:0]   FILL  = 16'hFFFF;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] address;
    logic          write_en;
    logic          read_en;
    logic [NB-1:0] byte_en;
    logic [DW-1:0] data_wr;

    logic [DW-1:0] data_rd0, data_rd1;
    logic          rd_valid0, rd_valid1;
    logic          ready0, ready1;
    logic          err0, err1;
    logic          dbg0, dbg1;

    mem_array_ctrl #(.ADDRESS_W(AW), .DATA_W(DW), .RD_PIPE(0), .FILL_VAL(FILL)) dut0 (
        .clk(clk), .rst(rst), .address(address), .write_en(write_en),
        .read_en(read_en), .byte_en(byte_en), .data_wr(data_wr),
        .data_rd(data_rd0), .rd_valid(rd_valid0), .ready(ready0),
        .err(err0), .dbg_state(dbg0)
    );

    mem_array_ctrl #(.ADDRESS_W(AW), .DATA_W(DW), .RD_PIPE(1), .FILL_VAL(FILL)) dut1 (
        .clk(clk), .rst(rst), .address(address), .write_en(write_en),
        .read_en(read_en), .byte_en(byte_en), .data_wr(data_wr),
        .data_rd(data_rd1), .rd_valid(rd_valid1), .ready(ready1),
        .err(err1), .dbg_state(dbg1)
    );

    // ---------------------------------------------------------------- counters
    int vectors     = 0;
    int miscompares = 0;

    // ---------------------------------------------------------------- reference model
    logic [DW-1:0] mem_m [DEPTH];
    int            k     = 0;       // rising edges seen with rst high
    int            cyc   = 0;       // absolute edge count
    logic          err_e = 1'b0;
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    int            due_q0 [$];
    int            due_q1 [$];
    logic [DW-1:0] last0 = '0;
    logic [DW-1:0] last1 = '0;
    bit            sb_en = 1'b0;

    task automatic model_reset();
        k     = 0;
        err_e = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        due_q0.delete();
        due_q1.delete();
        last0 = '0;
        last1 = '0;
    endtask

    // Edges 1..DEPTH after release fill the array; requests count from edge
    // DEPTH+2 onward (ready is seen high after edge DEPTH+1).
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                err_e = 1'b0;
            end else begin
                if (k < DEPTH) mem_m[k] = FILL;
                if (k >= DEPTH + 1) begin
                    err_e = 1'b0;
                    if (read_en) begin
                        exp_q0.push_back(mem_m[address]);
                        due_q0.push_back(cyc + 1);
                        exp_q1.push_back(mem_m[address]);
                        due_q1.push_back(cyc + 2);
                    end
                    if (write_en) begin
                        for (int b = 0; b < NB; b++) begin
                            if (byte_en[b]) mem_m[address][8*b +: 8] = data_wr[8*b +: 8];
                        end
                    end
                end else begin
                    err_e = write_en || read_en;
                end
                if (k < 100000) k++;
            end
        end
    end

    // ---------------------------------------------------------------- scoreboard
    initial begin : scoreboard
        logic exp_v0, exp_v1, exp_rdy;
        forever begin
            @(negedge clk);
            if (sb_en) begin
                exp_v0 = (due_q0.size() > 0) && (due_q0[0] == cyc);
                if (exp_v0) begin
                    last0 = exp_q0.pop_front();
                    void'(due_q0.pop_front());
                end
                exp_v1 = (due_q1.size() > 0) && (due_q1[0] == cyc);
                if (exp_v1) begin
                    last1 = exp_q1.pop_front();
                    void'(due_q1.pop_front());
                end
                exp_rdy = rst && (k >= DEPTH + 1);

                vectors++;
                if (rd_valid0 !== exp_v0) begin
                    miscompares++;
                    $display("FAIL sb_rd_valid0 cyc=%0d got=%b exp=%b", cyc, rd_valid0, exp_v0);
                end
                vectors++;
                if (data_rd0 !== last0) begin
                    miscompares++;
                    $display("FAIL sb_data_rd0 cyc=%0d got=%h exp=%h", cyc, data_rd0, last0);
                end
                vectors++;
                if (rd_valid1 !== exp_v1) begin
                    miscompares++;
                    $display("FAIL sb_rd_valid1 cyc=%0d got=%b exp=%b", cyc, rd_valid1, exp_v1);
                end
                vectors++;
                if (data_rd1 !== last1) begin
                    miscompares++;
                    $display("FAIL sb_data_rd1 cyc=%0d got=%h exp=%h", cyc, data_rd1, last1);
                end
                vectors++;
                if ({err0, err1} !== {err_e, err_e}) begin
                    miscompares++;
                    $display("FAIL sb_err cyc=%0d got=%b%b exp=%b", cyc, err0, err1, err_e);
                end
                vectors++;
                if ({ready0, ready1} !== {exp_rdy, exp_rdy}) begin
                    miscompares++;
                    $display("FAIL sb_ready cyc=%0d got=%b%b exp=%b", cyc, ready0, ready1, exp_rdy);
                end
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic idle_inputs();
        write_en = 1'b0;
        read_en  = 1'b0;
        address  = '0;
        byte_en  = '0;
        data_wr  = '0;
    endtask

    // Presents one request for one edge; returns #1 after the sampling edge.
    task automatic req(input logic we, input logic re, input logic [AW-1:0] a,
                       input logic [NB-1:0] be, input logic [DW-1:0] wd);
        write_en = we;
        read_en  = re;
        address  = a;
        byte_en  = be;
        data_wr  = wd;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready0 !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // ---------------------------------------------------------------- scenarios
    task automatic test_reset();
        int n;
        assert_reset();
        tick(3);
        vectors++;
        if ({data_rd0, rd_valid0, ready0, err0} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs0 got=%h/%b/%b/%b exp=0", data_rd0, rd_valid0, ready0, err0);
        end
        vectors++;
        if ({data_rd1, rd_valid1, ready1, err1} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs1 got=%h/%b/%b/%b exp=0", data_rd1, rd_valid1, ready1, err1);
        end
        rst = 1'b1;
        wait_ready(n);
        vectors++;
        if (n != DEPTH + 1) begin
            miscompares++;
            $display("FAIL ready_latency got=%0d exp=%0d", n, DEPTH + 1);
        end
        vectors++;
        if ({ready1, dbg0, dbg1} !== 3'b111) begin
            miscompares++;
            $display("FAIL run_state got=%b%b%b exp=111", ready1, dbg0, dbg1);
        end
        req(1'b0, 1'b1, 4'd5, 2'b00, 16'h0000);
        tick(1);
        vectors++;
        if (rd_valid0 !== 1'b1 || data_rd0 !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL fill_read0 got=%b/%h exp=1/ffff", rd_valid0, data_rd0);
        end
        tick(1);
        vectors++;
        if (rd_valid1 !== 1'b1 || data_rd1 !== 16'hFFFF || rd_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_read1 got=%b/%h v0=%b exp=1/ffff v0=0", rd_valid1, data_rd1, rd_valid0);
        end
    endtask

    task automatic test_byte_write();
        req(1'b1, 1'b0, 4'd3, 2'b01, 16'hA5A5);
        req(1'b0, 1'b1, 4'd3, 2'b00, 16'h0000);
        vectors++;
        if (rd_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL byte_early_valid got=%b exp=0", rd_valid0);
        end
        tick(1);
        vectors++;
        if (rd_valid0 !== 1'b1 || data_rd0 !== 16'hFFA5 || rd_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL byte_read0 got=%b/%h v1=%b exp=1/ffa5 v1=0", rd_valid0, data_rd0, rd_valid1);
        end
        tick(1);
        vectors++;
        if (rd_valid1 !== 1'b1 || data_rd1 !== 16'hFFA5 || rd_valid0 !== 1'b0 || data_rd0 !== 16'hFFA5) begin
            miscompares++;
            $display("FAIL byte_read1 got=%b/%h v0=%b/%h exp=1/ffa5 0/ffa5", rd_valid1, data_rd1, rd_valid0, data_rd0);
        end
    endtask

    task automatic test_read_before_write();
        req(1'b1, 1'b1, 4'd7, 2'b11, 16'h1234);
        tick(1);
        vectors++;
        if (rd_valid0 !== 1'b1 || data_rd0 !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL rbw_old got=%b/%h exp=1/ffff", rd_valid0, data_rd0);
        end
        req(1'b0, 1'b1, 4'd7, 2'b00, 16'h0000);
        tick(1);
        vectors++;
        if (rd_valid0 !== 1'b1 || data_rd0 !== 16'h1234) begin
            miscompares++;
            $display("FAIL rbw_new got=%b/%h exp=1/1234", rd_valid0, data_rd0);
        end
        tick(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 1'b0, AW'(i), 2'b11, DW'(i + 1));
        end
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            if (c < 4) begin
                read_en = 1'b1;
                address = AW'(c);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (c >= 1 && c <= 4) begin
                if (rd_valid0 !== 1'b1 || data_rd0 !== DW'(c)) begin
                    miscompares++;
                    $display("FAIL b2b_beat%0d got=%b/%h exp=1/%h", c, rd_valid0, data_rd0, DW'(c));
                end
            end else if (rd_valid0 !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_idle%0d got=%b exp=0", c, rd_valid0);
            end
        end
        idle_inputs();
        tick(2);
    endtask

    task automatic test_init_err();
        int n;
        assert_reset();
        tick(2);
        rst = 1'b1;
        tick(2);
        read_en = 1'b1;
        address = AW'($urandom_range(0, DEPTH - 1));
        @(posedge clk);
        #1;
        idle_inputs();
        vectors++;
        if (err0 !== 1'b1 || err1 !== 1'b1) begin
            miscompares++;
            $display("FAIL init_err_pulse got=%b%b exp=11", err0, err1);
        end
        tick(1);
        vectors++;
        if (err0 !== 1'b0 || rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL init_err_end got=%b v=%b%b exp=0 00", err0, rd_valid0, rd_valid1);
        end
        wait_ready(n);
        vectors++;
        if (n + 4 != DEPTH + 1) begin
            miscompares++;
            $display("FAIL init_err_ready got=%0d exp=%0d", n + 4, DEPTH + 1);
        end
        tick(3);
    endtask

    task automatic test_reset_inflight();
        int n;
        req(1'b0, 1'b1, 4'd9, 2'b00, 16'h0000);
        tick(1);
        #2;
        assert_reset();
        #1;
        vectors++;
        if ({data_rd0, rd_valid0, ready0, err0} !== 19'd0 ||
            {data_rd1, rd_valid1, ready1, err1} !== 19'd0) begin
            miscompares++;
            $display("FAIL async_reset got=%h/%b/%b %h/%b/%b exp=0",
                     data_rd0, rd_valid0, ready0, data_rd1, rd_valid1, ready1);
        end
        tick(4);
        vectors++;
        if (rd_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL inflight_discard got=%b exp=0", rd_valid1);
        end
        rst = 1'b1;
        wait_ready(n);
        vectors++;
        if (n != DEPTH + 1) begin
            miscompares++;
            $display("FAIL resweep_latency got=%0d exp=%0d", n, DEPTH + 1);
        end
        tick(2);
    endtask

    // Random traffic from reset release: the first cycles land in INIT and
    // must be rejected, the rest exercise byte masks and address overlaps.
    task automatic test_random();
        assert_reset();
        tick(1);
        rst = 1'b1;
        repeat (400) begin
            write_en = 1'($urandom_range(0, 1));
            read_en  = 1'($urandom_range(0, 1));
            address  = AW'($urandom_range(0, DEPTH - 1));
            byte_en  = NB'($urandom_range(0, 3));
            data_wr  = DW'($urandom());
            @(posedge clk);
            #1;
        end
        idle_inputs();
        tick(4);
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        idle_inputs();
        #2;
        assert_reset();
        sb_en = 1'b1;
        test_reset();
        test_byte_write();
        test_read_before_write();
        test_back_to_back();
        test_init_err();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
